// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: control-period tokens (common with the encoder)
// and the receive-side alignment lock states.
package tmds_pkg;

  localparam logic [9:0] CTL_TOK_00 = 10'b1101010100;
  localparam logic [9:0] CTL_TOK_01 = 10'b0010101011;
  localparam logic [9:0] CTL_TOK_10 = 10'b0101010100;
  localparam logic [9:0] CTL_TOK_11 = 10'b1010101011;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } lock_state_t;

endpackage

// File: rtl/tmds_decoder_tm_decode.sv
// Combinational inverse of the encoder's transition-minimisation stage:
// undo the optional DC-balance inversion, then undo the XOR/XNOR chain.
module tm_decode (
  input  logic [9:0] sym,
  output logic [7:0] data
);

  logic [7:0] q;

  always_comb begin
    q       = sym[9] ? ~sym[7:0] : sym[7:0];
    data    = '0;
    data[0] = q[0];
    for (int i = 1; i < 8; i++) begin
      data[i] = sym[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
    end
  end

endmodule

// File: rtl/tmds_decoder.sv
// Per-channel TMDS symbol decoder with control-run based alignment lock and
// bitslip request generation toward the upstream 10:1 deserializer.
module tmds_decoder
  import tmds_pkg::*;
#(
  parameter int CTL_RUN      = 8,
  parameter int LOCK_RUNS    = 3,
  parameter int SLIP_TIMEOUT = 2048
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic [9:0] tmds_in,
  output logic [7:0] data_out,
  output logic [1:0] control_out,
  output logic       ve_out,
  output logic       locked_out,
  output logic       bitslip_out
);

  localparam int CW = $clog2(CTL_RUN + 1);
  localparam int TW = $clog2(SLIP_TIMEOUT + 1);
  localparam int GW = $clog2(LOCK_RUNS + 1);

  // Stage p0: combinational classification and decode of the incoming symbol
  logic       is_ctl_p0;
  logic [1:0] ctl_idx_p0;
  logic [7:0] dec_data_p0;

  tm_decode u_tm_decode (
    .sym  (tmds_in),
    .data (dec_data_p0)
  );

  always_comb begin
    is_ctl_p0  = 1'b1;
    ctl_idx_p0 = 2'd0;
    unique case (tmds_in)
      CTL_TOK_00: ctl_idx_p0 = 2'd0;
      CTL_TOK_01: ctl_idx_p0 = 2'd1;
      CTL_TOK_10: ctl_idx_p0 = 2'd2;
      CTL_TOK_11: ctl_idx_p0 = 2'd3;
      default:    is_ctl_p0  = 1'b0;
    endcase
  end

  logic [CW-1:0] ctl_cnt;
  logic [TW-1:0] to_cnt;
  logic [GW-1:0] good_cnt, good_nxt;
  lock_state_t   state, state_nxt;
  logic          run_evt, timeout, slip_nxt;

  // Saturating the run counter at CTL_RUN makes run_evt fire once per run.
  assign run_evt = is_ctl_p0 && (ctl_cnt == CW'(CTL_RUN - 1));
  assign timeout = (to_cnt == TW'(SLIP_TIMEOUT - 1)) && !run_evt;

  always_comb begin
    state_nxt = state;
    good_nxt  = good_cnt;
    slip_nxt  = 1'b0;
    unique case (state)
      HUNT: begin
        if (run_evt) begin
          good_nxt  = GW'(1);
          state_nxt = (LOCK_RUNS <= 1) ? LOCKED : VERIFY;
        end else if (timeout) begin
          slip_nxt = 1'b1;
        end
      end
      VERIFY: begin
        if (run_evt) begin
          good_nxt = good_cnt + GW'(1);
          if (good_nxt >= GW'(LOCK_RUNS)) state_nxt = LOCKED;
        end else if (timeout) begin
          slip_nxt  = 1'b1;
          good_nxt  = '0;
          state_nxt = HUNT;
        end
      end
      LOCKED: begin
        // Loss of lock returns to HUNT quietly; the next HUNT timeout slips.
        if (timeout) begin
          good_nxt  = '0;
          state_nxt = HUNT;
        end
      end
      default: begin
        good_nxt  = '0;
        state_nxt = HUNT;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state    <= HUNT;
      good_cnt <= '0;
      ctl_cnt  <= '0;
      to_cnt   <= '0;
    end else begin
      state    <= state_nxt;
      good_cnt <= good_nxt;
      if (!is_ctl_p0)                      ctl_cnt <= '0;
      else if (ctl_cnt != CW'(CTL_RUN))    ctl_cnt <= ctl_cnt + CW'(1);
      if (run_evt || timeout)              to_cnt  <= '0;
      else                                 to_cnt  <= to_cnt + TW'(1);
    end
  end

  // Stage p1: registered decode outputs and bitslip pulse
  logic [7:0] data_p1;
  logic [1:0] ctl_p1;
  logic       ve_p1;
  logic       slip_p1;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      data_p1 <= '0;
      ctl_p1  <= '0;
      ve_p1   <= 1'b0;
      slip_p1 <= 1'b0;
    end else begin
      data_p1 <= is_ctl_p0 ? 8'h00 : dec_data_p0;
      ctl_p1  <= is_ctl_p0 ? ctl_idx_p0 : 2'd0;
      ve_p1   <= !is_ctl_p0;
      slip_p1 <= slip_nxt;
    end
  end

  assign data_out    = data_p1;
  assign control_out = ctl_p1;
  assign ve_out      = ve_p1;
  assign bitslip_out = slip_p1;
  assign locked_out  = (state == LOCKED);

endmodule

// File: tb/tb_tmds_decoder.sv
// Self-checking bench for tmds_decoder: a reference TMDS encoder feeds the
// decoder, expected decodes travel through a scoreboard queue.
module tb_tmds_decoder;

  logic       clk_in = 1'b0;
  logic       rst_in = 1'b0;
  logic [9:0] tmds_in = '0;
  logic [7:0] data_out;
  logic [1:0] control_out;
  logic       ve_out, locked_out, bitslip_out;

  always #5 clk_in = ~clk_in;

  tmds_decoder #(
    .CTL_RUN      (8),
    .LOCK_RUNS    (3),
    .SLIP_TIMEOUT (2048)
  ) dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .tmds_in     (tmds_in),
    .data_out    (data_out),
    .control_out (control_out),
    .ve_out      (ve_out),
    .locked_out  (locked_out),
    .bitslip_out (bitslip_out)
  );

  typedef struct packed {
    logic        chk;
    logic [10:0] val;   // {ve, control[1:0], data[7:0]}
  } exp_t;

  exp_t       sb[$];
  logic [9:0] tok [4] = '{10'b1101010100, 10'b0010101011,
                          10'b0101010100, 10'b1010101011};
  int   n_vec = 0, n_err = 0;
  int   disp = 0, nsym = 0, slip_cnt = 0, strm = 0;
  logic obs_locked = 1'b0, obs_slip = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (symbol %0d)", tag, got, exp, nsym);
    end
  endtask

  // Reference DVI TMDS encoder with running disparity.
  task automatic tmds_enc(input logic [7:0] d, output logic [9:0] s);
    logic [8:0] qm;
    int n1, n1q, n0q;
    n1 = $countones(d);
    qm = '0;
    qm[0] = d[0];
    if (n1 > 4 || (n1 == 4 && !d[0])) begin
      for (int i = 1; i < 8; i++) qm[i] = ~(qm[i-1] ^ d[i]);
      qm[8] = 1'b0;
    end else begin
      for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ d[i];
      qm[8] = 1'b1;
    end
    n1q = $countones(qm[7:0]);
    n0q = 8 - n1q;
    if (disp == 0 || n1q == n0q) begin
      s = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
      disp += qm[8] ? (n1q - n0q) : (n0q - n1q);
    end else if ((disp > 0 && n1q > n0q) || (disp < 0 && n0q > n1q)) begin
      s = {1'b1, qm[8], ~qm[7:0]};
      disp += (qm[8] ? 2 : 0) + n0q - n1q;
    end else begin
      s = {1'b0, qm[8], qm[7:0]};
      disp += (qm[8] ? 0 : -2) + n1q - n0q;
    end
  endtask

  // Drive one symbol at a falling edge, then compare its decode one edge later.
  task automatic cycle(input logic [9:0] sym, input logic chk, input logic [10:0] val);
    exp_t e;
    e.chk = chk;
    e.val = val;
    tmds_in = sym;
    sb.push_back(e);
    @(negedge clk_in);
    if (sb.size() == 0) begin
      check("sb_underflow", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      if (e.chk) check("decode", 32'({ve_out, control_out, data_out}), 32'(e.val));
    end
    obs_locked = locked_out;
    obs_slip   = bitslip_out;
    if (bitslip_out) slip_cnt++;
    nsym++;
  endtask

  task automatic send_ctl(input int idx);
    disp = 0;
    cycle(tok[idx], 1'b1, {1'b0, 2'(idx), 8'h00});
  endtask

  task automatic send_data(input logic [7:0] d);
    logic [9:0] s;
    tmds_enc(d, s);
    cycle(s, 1'b1, {3'b100, d});
  endtask

  // Repeating 8-token control period followed by 50 data symbols.
  task automatic send_stream(input logic rot);
    logic [9:0]  s;
    logic [10:0] v;
    logic [7:0]  d;
    if ((strm % 58) < 8) begin
      disp = 0;
      s = tok[0];
      v = 11'h000;
    end else begin
      d = 8'($urandom);
      tmds_enc(d, s);
      v = {3'b100, d};
    end
    strm++;
    if (rot) cycle({s[0], s[9:1]}, 1'b0, v);
    else     cycle(s, 1'b1, v);
  endtask

  task automatic do_reset();
    rst_in = 1'b0;
    sb.delete();
    for (int i = 0; i < 4; i++) begin
      tmds_in = 10'($urandom);
      @(negedge clk_in);
      check("reset_outputs",
            32'({data_out, control_out, ve_out, locked_out, bitslip_out}), 32'd0);
    end
    rst_in   = 1'b1;
    nsym     = 0;
    slip_cnt = 0;
    strm     = 0;
    disp     = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, n_vec=%0d n_err=%0d", n_vec, n_err);
    $fatal(1);
  end

  initial begin
    // Reset and basic control decode
    do_reset();
    send_ctl(3);
    for (int i = 0; i < 4; i++) send_ctl(i);
    send_ctl(2);
    send_ctl(1);

    // All 256 data values through the reference encoder
    for (int v = 0; v < 256; v++) send_data(8'(v));
    for (int v = 0; v < 40; v++) send_data(8'($urandom));

    // Three full runs reach lock on the 8th token of run 3
    do_reset();
    for (int r = 0; r < 3; r++) begin
      for (int t = 0; t < 8; t++) begin
        send_ctl(0);
        if (t == 7)                check("lock_after_run", 32'(obs_locked), 32'(r == 2));
        else if (r == 2 && t == 6) check("lock_7th_token", 32'(obs_locked), 32'd0);
      end
      for (int i = 0; i < 100; i++) send_data(8'($urandom));
    end
    check("lock_held", 32'(obs_locked), 32'd1);
    check("lock_no_slip", 32'(slip_cnt), 32'd0);

    // Runs of 7 tokens never lock
    do_reset();
    for (int r = 0; r < 5; r++) begin
      for (int t = 0; t < 7; t++) send_ctl(r % 4);
      for (int i = 0; i < 20; i++) send_data(8'($urandom));
      check("run7_no_lock", 32'(obs_locked), 32'd0);
    end
    check("run7_no_slip", 32'(slip_cnt), 32'd0);

    // Misaligned stream: bitslip every 2048 symbols
    do_reset();
    repeat (3 * 2048 + 10) begin
      send_stream(1'b1);
      check("slip_timing", 32'(obs_slip), 32'((nsym % 2048) == 0));
    end
    check("slip_count", 32'(slip_cnt), 32'd3);
    check("misalign_no_lock", 32'(obs_locked), 32'd0);

    // Aligned stream again: lock without further slips
    slip_cnt = 0;
    repeat (5 * 58) send_stream(1'b0);
    check("relock", 32'(obs_locked), 32'd1);
    check("relock_no_slip", 32'(slip_cnt), 32'd0);

    // Loss of signal from LOCKED: lock drops, no slip pulse
    repeat (1000) send_data(8'($urandom));
    check("loss_still_locked", 32'(obs_locked), 32'd1);
    repeat (1048) send_data(8'($urandom));
    check("loss_unlocked", 32'(obs_locked), 32'd0);
    check("loss_no_slip", 32'(slip_cnt), 32'd0);

    // Reset in the middle of a control run clears the run and lock counters
    for (int t = 0; t < 4; t++) send_ctl(0);
    do_reset();
    for (int t = 0; t < 4; t++) send_ctl(0);
    for (int i = 0; i < 20; i++) send_data(8'($urandom));
    check("partial_no_lock", 32'(obs_locked), 32'd0);
    for (int r = 0; r < 3; r++) begin
      for (int t = 0; t < 8; t++) send_ctl(1);
      check("post_reset_lock", 32'(obs_locked), 32'(r == 2));
      for (int i = 0; i < 30; i++) send_data(8'($urandom));
    end

    // Asynchronous reset while locked clears outputs without a clock edge
    #2 rst_in = 1'b0;
    #1 check("async_reset",
             32'({data_out, control_out, ve_out, locked_out, bitslip_out}), 32'd0);
    do_reset();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
